// File: rtl/serial_multiplier.sv
// Bit-serial shift-and-add multiplier: one multiplier bit per clock, full-width product.
// Define SERIAL_MUL_SIGNED_EN for two's-complement operands and product.
module serial_multiplier #(
    parameter int A_WIDTH = 8,
    parameter int B_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [A_WIDTH-1:0]         multiplicand,
    input  logic [B_WIDTH-1:0]         multiplier,
    output logic [A_WIDTH+B_WIDTH-1:0] product,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 state_dbg
);
    localparam int CW = $clog2(B_WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [A_WIDTH-1:0] a_q,    a_d;
    logic [A_WIDTH:0]   acc_q,  acc_d;
    logic [B_WIDTH-1:0] b_q,    b_d;
    logic [CW-1:0]      cnt_q,  cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [A_WIDTH:0]   sum;
    logic               ins_bit;

`ifdef SERIAL_MUL_SIGNED_EN
    // The multiplier MSB has negative weight, so the last partial product is subtracted.
    logic [A_WIDTH:0] a_ext;
    always_comb begin
        a_ext = {a_q[A_WIDTH-1], a_q};
        sum   = acc_q;
        if (b_q[0]) begin
            if (cnt_q == CW'(1)) sum = acc_q - a_ext;
            else                 sum = acc_q + a_ext;
        end
        ins_bit = sum[A_WIDTH];
    end
`else
    logic [A_WIDTH+1:0] sum_w;
    always_comb begin
        sum_w   = {1'b0, acc_q} + (b_q[0] ? {2'b00, a_q} : '0);
        sum     = sum_w[A_WIDTH:0];
        ins_bit = sum_w[A_WIDTH+1];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            acc_q  <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            acc_q  <= acc_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        a_d    = a_q;
        acc_d  = acc_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = done_q;
        if (start) begin
            a_d    = multiplicand;
            b_d    = multiplier;
            acc_d  = '0;
            cnt_d  = CW'(B_WIDTH);
            busy_d = 1'b1;
            done_d = 1'b0;
        end else if (cnt_q != '0) begin
            acc_d = {ins_bit, sum[A_WIDTH:1]};
            b_d   = {sum[0], b_q[B_WIDTH-1:1]};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_comb begin
        product   = {acc_q[A_WIDTH-1:0], b_q};
        busy      = busy_q;
        done      = done_q;
        state_dbg = ST_IDLE;
        if (done_q)      state_dbg = ST_DONE;
        else if (busy_q) state_dbg = ST_RUN;
    end
endmodule
